// File: rtl/seq_parser_p.sv
// Packs input words into fixed-size byte messages and queues them; optional drop counter via SEQ_PARSER_LOSTCNT_EN.
// Latency: the message appears on dataOut one cycle after its last beat. Input is never backpressured.
// Backpressure: a full queue drops the completed message and pulses packetLost, unless a pop lands on the same edge.

module seq_parser_p_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rdPtr];

    // A push while full is legal when a pop happens on the same edge.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end
endmodule

module seq_parser_p #(
    parameter int IN_W      = 32,
    parameter int OUT_BYTES = 37,
    parameter int DEPTH     = 2
) (
    input  logic                               clk,
    input  logic                               reset_b,
    input  logic [IN_W-1:0]                    dataIn,
    input  logic                               dataIn_val,
    output logic                               dataIn_ready,
    input  logic                               dataIN_last,
    output logic [0:OUT_BYTES*8-1]             dataOut,
    output logic [$clog2(OUT_BYTES+1)-1:0]     dataOut_len,
    output logic                               dataOut_val,
    input  logic                               dataOut_ready,
    output logic                               packetLost
`ifdef SEQ_PARSER_LOSTCNT_EN
    ,
    output logic [15:0]                        lostCount
`endif
);
    localparam int NB = IN_W / 8;
    localparam int LW = $clog2(OUT_BYTES + 1);
    localparam int IW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int MW = OUT_BYTES * 8;
    localparam int EW = LW + MW;

    logic [7:0]    asmBuf  [OUT_BYTES];
    logic [7:0]    asmNext [OUT_BYTES];
    logic [LW-1:0] bytePtr;
    logic [LW-1:0] ptrNext;
    logic [0:MW-1] msgData;
    logic [0:MW-1] headData;
    logic [LW-1:0] headLen;
    logic [EW-1:0] head;
    logic          accept;
    logic          done;
    logic          pop;
    logic          push;
    logic          lost;
    logic          fifoFull;
    logic          fifoEmpty;

    assign dataIn_ready = !reset_b;
    assign accept       = dataIn_val && dataIn_ready;
    assign done         = accept && dataIN_last;
    assign dataOut_val  = !fifoEmpty;
    assign pop          = dataOut_val && dataOut_ready;
    assign push         = done && (!fifoFull || pop);
    assign lost         = done && fifoFull && !pop;

    // Merge the current beat into the buffer; bytes beyond OUT_BYTES fall off.
    always_comb begin
        int idx;
        asmNext = asmBuf;
        ptrNext = bytePtr;
        msgData = '0;
        idx     = 0;
        if (accept) begin
            for (int i = 0; i < NB; i++) begin
                idx = int'(bytePtr) + i;
                if (idx < OUT_BYTES) asmNext[IW'(idx)] = dataIn[IN_W-1-8*i -: 8];
            end
            if (int'(bytePtr) + NB >= OUT_BYTES) ptrNext = LW'(OUT_BYTES);
            else                                 ptrNext = bytePtr + LW'(NB);
        end
        for (int k = 0; k < OUT_BYTES; k++) msgData[8*k +: 8] = asmNext[k];
    end

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            for (int k = 0; k < OUT_BYTES; k++) asmBuf[k] <= '0;
            bytePtr    <= '0;
            packetLost <= 1'b0;
        end else begin
            packetLost <= lost;
            if (accept) begin
                if (dataIN_last) begin
                    for (int k = 0; k < OUT_BYTES; k++) asmBuf[k] <= '0;
                    bytePtr <= '0;
                end else begin
                    asmBuf  <= asmNext;
                    bytePtr <= ptrNext;
                end
            end
        end
    end

    seq_parser_p_fifo #(.W(EW), .DEPTH(DEPTH)) msgFifo (
        .clk      (clk),
        .reset_b  (reset_b),
        .push     (push),
        .pushData ({ptrNext, msgData}),
        .pop      (pop),
        .head     (head),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign headLen     = head[EW-1 -: LW];
    assign headData    = head[MW-1:0];
    // Stale FIFO storage is masked so an empty queue presents zeros.
    assign dataOut     = dataOut_val ? headData : '0;
    assign dataOut_len = dataOut_val ? headLen  : '0;

`ifdef SEQ_PARSER_LOSTCNT_EN
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b)                                  lostCount <= '0;
        else if (packetLost && lostCount != 16'hFFFF) lostCount <= lostCount + 16'd1;
    end
`endif
endmodule

// File: doc/seq_parser_p.md
SEQ_PARSER_P -- requirements
Module: seq_parser_p

Interface
REQ-001 Parameter IN_W, default 32, input word width in bits; multiple of 8, range 8..128.
REQ-002 Parameter OUT_BYTES, default 37, message size in bytes; range 1..64.
REQ-003 Parameter DEPTH, default 2, output message FIFO depth; power of 2, minimum 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_b  in  1  reset, asynchronous, active-high.
REQ-006 dataIn  in  IN_W  input word; dataIn[IN_W-1:IN_W-8] is the first byte.
REQ-007 dataIn_val  in  1  dataIn valid.
REQ-008 dataIn_ready  out  1  input ready.
REQ-009 dataIN_last  in  1  marks final word of a packet; qualified by dataIn_val.
REQ-010 dataOut  out  OUT_BYTES*8  message, indexed [0:OUT_BYTES*8-1]; packet byte k at bits [8k:8k+7].
REQ-011 dataOut_len  out  clog2(OUT_BYTES+1)  valid byte count of the head message.
REQ-012 dataOut_val  out  1  head message valid.
REQ-013 dataOut_ready  in  1  consumer accepts the head message.
REQ-014 packetLost  out  1  one-cycle pulse per dropped message.

Function
REQ-015 A beat is accepted when dataIn_val and dataIn_ready are both 1 at a rising edge; dataIn_ready SHALL be 1 whenever reset_b is low (no input backpressure).
REQ-016 Each accepted beat SHALL append IN_W/8 bytes to the assembly buffer, MSB byte first, at the current byte pointer.
REQ-017 Bytes landing at index >= OUT_BYTES SHALL be discarded; the byte pointer SHALL saturate at OUT_BYTES.
REQ-018 Unwritten bytes of a message SHALL read as 0x00.
REQ-019 A beat with dataIN_last=1 SHALL complete the packet; length = min(total packet bytes, OUT_BYTES); assembly buffer and pointer clear on the same edge.
REQ-020 A completed message SHALL be written into the FIFO on the completing edge; dataOut_val SHALL rise the next cycle when the FIFO was empty (latency 1 cycle from last beat).
REQ-021 A message is popped at an edge where dataOut_val and dataOut_ready are 1; dataOut/dataOut_len SHALL hold stable while dataOut_val=1 and dataOut_ready=0.
REQ-022 If the FIFO is full at the completing edge and no pop occurs on that edge, the message SHALL be dropped and packetLost SHALL be 1 for exactly the following cycle.
REQ-023 If the FIFO is full and a pop coincides with completion, the message SHALL be stored, no loss.
REQ-024 With dataIn_val=0 the assembly state SHALL hold indefinitely.
REQ-025 Consecutive packets SHALL be supported back-to-back with no idle cycle; single-word packets (first beat is last) SHALL be supported.
REQ-026 FIFO ordering SHALL be first-in first-out; read/write pointers wrap modulo DEPTH.

Reset
REQ-027 While reset_b=1: dataIn_ready=0, dataOut_val=0, dataOut=0, dataOut_len=0, packetLost=0, FIFO empty, assembly buffer cleared, byte pointer 0.
REQ-028 Reset asserted mid-packet SHALL discard the partial packet and all queued messages without asserting packetLost.
REQ-029 The first beat after reset release SHALL be byte 0 of a new packet.

Configuration
REQ-030 Macro SEQ_PARSER_LOSTCNT_EN defined: adds output lostCount (16 bits) counting dropped messages, saturating at 0xFFFF, reset to 0, incremented on each packetLost pulse.
REQ-031 Macro SEQ_PARSER_LOSTCNT_EN undefined: port lostCount and its counter SHALL not exist; all other behaviour identical.

Verification (IN_W=32, OUT_BYTES=37, DEPTH=2)
REQ-032 Hold reset_b=1 for 3 cycles with random inputs -> all outputs 0; first beat after release lands in byte 0.
REQ-033 Packet of 10 words 0x00000001..0x0000000A, last on word 10, dataOut_ready=1 -> one message 1 cycle later, len=37, bytes 0..35 = words 1..9, byte 36 = 0x00, remaining word-10 bytes discarded.
REQ-034 Packet 0xAABBCCDD, 0x11223344 (last) -> len=8, dataOut[0:63]=0xAABBCCDD11223344, all other bits 0.
REQ-035 dataOut_ready=0, three single-word packets 0x1,0x2,0x3 -> first two held in order, third dropped, packetLost one pulse, lostCount=1 (macro on); then ready=1 -> pops 0x1 then 0x2.
REQ-036 FIFO full, dataOut_ready=1 on the same edge a packet completes -> new message stored, packetLost stays 0, FIFO stays full.
REQ-037 Reset asserted after 3 words of a packet -> no message produced, packetLost=0, next packet assembles from byte 0.
